// File: rtl/axi_wr_arbiter_if.sv
// Write-channel bundle for the two-master AXI write arbiter.
// Holds both master ports and the shared slave port.
interface axi_wr_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   m0_awid_i,   m1_awid_i,   s_awid_o;
    logic [ADDR_W-1:0] m0_awaddr_i, m1_awaddr_i, s_awaddr_o;
    logic              m0_awvalid_i, m1_awvalid_i, s_awvalid_o;
    logic              m0_awready_o, m1_awready_o, s_awready_i;
    logic [DATA_W-1:0] m0_wdata_i,  m1_wdata_i,  s_wdata_o;
    logic [STRB_W-1:0] m0_wstrb_i,  m1_wstrb_i,  s_wstrb_o;
    logic              m0_wvalid_i, m1_wvalid_i, s_wvalid_o;
    logic              m0_wready_o, m1_wready_o, s_wready_i;
    logic [ID_W-1:0]   m0_bid_o,    m1_bid_o,    s_bid_i;
    logic [1:0]        m0_bresp_o,  m1_bresp_o,  s_bresp_i;
    logic              m0_bvalid_o, m1_bvalid_o, s_bvalid_i;
    logic              m0_bready_i, m1_bready_i, s_bready_o;

    // Arbiter side
    modport slave (
        input  m0_awid_i, m1_awid_i, m0_awaddr_i, m1_awaddr_i,
        input  m0_awvalid_i, m1_awvalid_i,
        input  m0_wdata_i, m1_wdata_i, m0_wstrb_i, m1_wstrb_i,
        input  m0_wvalid_i, m1_wvalid_i, m0_bready_i, m1_bready_i,
        input  s_awready_i, s_wready_i, s_bid_i, s_bresp_i, s_bvalid_i,
        output m0_awready_o, m1_awready_o, m0_wready_o, m1_wready_o,
        output m0_bid_o, m1_bid_o, m0_bresp_o, m1_bresp_o,
        output m0_bvalid_o, m1_bvalid_o,
        output s_awid_o, s_awaddr_o, s_awvalid_o,
        output s_wdata_o, s_wstrb_o, s_wvalid_o, s_bready_o
    );

    // Environment side (masters plus slave device)
    modport master (
        output m0_awid_i, m1_awid_i, m0_awaddr_i, m1_awaddr_i,
        output m0_awvalid_i, m1_awvalid_i,
        output m0_wdata_i, m1_wdata_i, m0_wstrb_i, m1_wstrb_i,
        output m0_wvalid_i, m1_wvalid_i, m0_bready_i, m1_bready_i,
        output s_awready_i, s_wready_i, s_bid_i, s_bresp_i, s_bvalid_i,
        input  m0_awready_o, m1_awready_o, m0_wready_o, m1_wready_o,
        input  m0_bid_o, m1_bid_o, m0_bresp_o, m1_bresp_o,
        input  m0_bvalid_o, m1_bvalid_o,
        input  s_awid_o, s_awaddr_o, s_awvalid_o,
        input  s_wdata_o, s_wstrb_o, s_wvalid_o, s_bready_o
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter (AW/W/B), one transaction in flight.
// Define AXI_WR_ARB_RR_EN for round-robin; default is fixed priority.
module axi_wr_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                areset,
    axi_wr_arbiter_if.slave     bus,
    output logic [1:0]          grant_o,
    output logic                busy_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
`ifdef AXI_WR_ARB_RR_EN
    logic       last_q, last_d;
`endif

    logic [1:0]        req;
    logic [1:0]        win;
    logic              in_xfer, in_resp;
    logic              aw_hs, w_hs, b_hs;
    logic [ID_W-1:0]   sel_awid;
    logic [ADDR_W-1:0] sel_awaddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_awvalid, sel_wvalid, sel_bready;

    assign req     = {bus.m1_awvalid_i, bus.m0_awvalid_i};
    assign in_xfer = (state_q == XFER);
    assign in_resp = (state_q == RESP);

    // Winner selection among pending AW requests
    always_comb begin
`ifdef AXI_WR_ARB_RR_EN
        if (req == 2'b11) begin
            win = last_q ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
`else
        win = req[0] ? 2'b01 : req;
`endif
    end

    // Mux the granted master's request side
    always_comb begin
        sel_awid    = '0;
        sel_awaddr  = '0;
        sel_awvalid = 1'b0;
        sel_wdata   = '0;
        sel_wstrb   = '0;
        sel_wvalid  = 1'b0;
        sel_bready  = 1'b0;
        unique case (1'b1)
            grant_q[0]: begin
                sel_awid    = bus.m0_awid_i;
                sel_awaddr  = bus.m0_awaddr_i;
                sel_awvalid = bus.m0_awvalid_i;
                sel_wdata   = bus.m0_wdata_i;
                sel_wstrb   = bus.m0_wstrb_i;
                sel_wvalid  = bus.m0_wvalid_i;
                sel_bready  = bus.m0_bready_i;
            end
            grant_q[1]: begin
                sel_awid    = bus.m1_awid_i;
                sel_awaddr  = bus.m1_awaddr_i;
                sel_awvalid = bus.m1_awvalid_i;
                sel_wdata   = bus.m1_wdata_i;
                sel_wstrb   = bus.m1_wstrb_i;
                sel_wvalid  = bus.m1_wvalid_i;
                sel_bready  = bus.m1_bready_i;
            end
            default: ;
        endcase
    end

    // Valids drop once their channel has completed in this transaction
    assign bus.s_awid_o    = sel_awid;
    assign bus.s_awaddr_o  = sel_awaddr;
    assign bus.s_awvalid_o = in_xfer & ~aw_done_q & sel_awvalid;
    assign bus.s_wdata_o   = sel_wdata;
    assign bus.s_wstrb_o   = sel_wstrb;
    assign bus.s_wvalid_o  = in_xfer & ~w_done_q & sel_wvalid;
    assign bus.s_bready_o  = in_resp & sel_bready;

    assign aw_hs = bus.s_awvalid_o & bus.s_awready_i;
    assign w_hs  = bus.s_wvalid_o & bus.s_wready_i;
    assign b_hs  = bus.s_bvalid_i & bus.s_bready_o;

    assign bus.m0_awready_o = in_xfer & grant_q[0] & ~aw_done_q
                            & bus.s_awready_i;
    assign bus.m1_awready_o = in_xfer & grant_q[1] & ~aw_done_q
                            & bus.s_awready_i;
    assign bus.m0_wready_o  = in_xfer & grant_q[0] & ~w_done_q
                            & bus.s_wready_i;
    assign bus.m1_wready_o  = in_xfer & grant_q[1] & ~w_done_q
                            & bus.s_wready_i;
    assign bus.m0_bvalid_o  = in_resp & grant_q[0] & bus.s_bvalid_i;
    assign bus.m1_bvalid_o  = in_resp & grant_q[1] & bus.s_bvalid_i;
    assign bus.m0_bid_o     = (in_resp & grant_q[0]) ? bus.s_bid_i : '0;
    assign bus.m1_bid_o     = (in_resp & grant_q[1]) ? bus.s_bid_i : '0;
    assign bus.m0_bresp_o   = (in_resp & grant_q[0]) ? bus.s_bresp_i : '0;
    assign bus.m1_bresp_o   = (in_resp & grant_q[1]) ? bus.s_bresp_i : '0;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    // Next-state: grant in IDLE, track AW/W completion, release on B
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef AXI_WR_ARB_RR_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = win;
                    state_d   = XFER;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef AXI_WR_ARB_RR_EN
                    last_d    = win[1];
`endif
                end
            end
            XFER: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d   = RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // State registers; reset favours master 0 on the first tie
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXI_WR_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXI_WR_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: directed master/slave traffic,
// expectations queued at issue time and checked by a monitor.
module tb_axi_wr_arbiter;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SW     = DATA_W / 8;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic [1:0] grant_o;
    logic busy_o;

    always #5 clk = ~clk;

    axi_wr_arbiter_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    axi_wr_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .areset(areset),
        .bus(bus),
        .grant_o(grant_o),
        .busy_o(busy_o)
    );

    logic [ID_W-1:0]   m_awid[2];
    logic [ADDR_W-1:0] m_awaddr[2];
    logic              m_awvalid[2];
    logic [DATA_W-1:0] m_wdata[2];
    logic [SW-1:0]     m_wstrb[2];
    logic              m_wvalid[2];
    logic              m_bready[2];
    logic              m_awready[2];
    logic              m_wready[2];
    logic              m_bvalid[2];
    logic [ID_W-1:0]   m_bid[2];
    logic [1:0]        m_bresp[2];

    logic            sl_awready, sl_wready, sl_bvalid;
    logic [ID_W-1:0] sl_bid;
    logic [1:0]      sl_bresp;
    int              bdelay;
    logic [1:0]      bresp_cfg;

    assign bus.m0_awid_i    = m_awid[0];
    assign bus.m1_awid_i    = m_awid[1];
    assign bus.m0_awaddr_i  = m_awaddr[0];
    assign bus.m1_awaddr_i  = m_awaddr[1];
    assign bus.m0_awvalid_i = m_awvalid[0];
    assign bus.m1_awvalid_i = m_awvalid[1];
    assign bus.m0_wdata_i   = m_wdata[0];
    assign bus.m1_wdata_i   = m_wdata[1];
    assign bus.m0_wstrb_i   = m_wstrb[0];
    assign bus.m1_wstrb_i   = m_wstrb[1];
    assign bus.m0_wvalid_i  = m_wvalid[0];
    assign bus.m1_wvalid_i  = m_wvalid[1];
    assign bus.m0_bready_i  = m_bready[0];
    assign bus.m1_bready_i  = m_bready[1];
    assign m_awready[0] = bus.m0_awready_o;
    assign m_awready[1] = bus.m1_awready_o;
    assign m_wready[0]  = bus.m0_wready_o;
    assign m_wready[1]  = bus.m1_wready_o;
    assign m_bvalid[0]  = bus.m0_bvalid_o;
    assign m_bvalid[1]  = bus.m1_bvalid_o;
    assign m_bid[0]     = bus.m0_bid_o;
    assign m_bid[1]     = bus.m1_bid_o;
    assign m_bresp[0]   = bus.m0_bresp_o;
    assign m_bresp[1]   = bus.m1_bresp_o;
    assign bus.s_awready_i = sl_awready;
    assign bus.s_wready_i  = sl_wready;
    assign bus.s_bvalid_i  = sl_bvalid;
    assign bus.s_bid_i     = sl_bid;
    assign bus.s_bresp_i   = sl_bresp;

    int errors = 0;
    int checks = 0;

    logic [1:0]             exp_grant[$];
    logic [ID_W+ADDR_W-1:0] exp_aw[$];
    logic [DATA_W+SW-1:0]   exp_w[$];
    logic [ID_W+2:0]        exp_b[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    // Queue everything one master transaction should produce
    task automatic push(input int n, input logic [ID_W-1:0] id,
                        input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data,
                        input logic [SW-1:0] strb, input logic [1:0] resp);
        logic nb;
        nb = n[0];
        exp_grant.push_back(nb ? 2'b10 : 2'b01);
        exp_aw.push_back({id, addr});
        exp_w.push_back({data, strb});
        exp_b.push_back({nb, id, resp});
    endtask

    task automatic m_write(input int n, input logic [ID_W-1:0] id,
                           input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data,
                           input logic [SW-1:0] strb,
                           input int w_lead, input bit early_b);
        bit aw_hs, w_hs, b_hs, aw_ok, w_ok, b_ok;
        int t;
        m_awid[n]   = id;
        m_awaddr[n] = addr;
        m_wdata[n]  = data;
        m_wstrb[n]  = strb;
        m_bready[n] = early_b;
        if (w_lead > 0) begin
            m_wvalid[n] = 1'b1;
            repeat (w_lead) @(posedge clk);
            #1;
        end
        m_awvalid[n] = 1'b1;
        m_wvalid[n]  = 1'b1;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        t = 0;
        while (!(aw_ok && w_ok) && t < 200) begin
            @(negedge clk);
            aw_hs = m_awvalid[n] && m_awready[n];
            w_hs  = m_wvalid[n] && m_wready[n];
            @(posedge clk);
            #1;
            if (aw_hs) begin
                m_awvalid[n] = 1'b0;
                aw_ok = 1'b1;
            end
            if (w_hs) begin
                m_wvalid[n] = 1'b0;
                w_ok = 1'b1;
            end
            t++;
        end
        m_awvalid[n] = 1'b0;
        m_wvalid[n]  = 1'b0;
        chk("aw_w_timeout", {62'd0, aw_ok, w_ok}, 64'd3);
        m_bready[n] = 1'b1;
        b_ok = 1'b0;
        t = 0;
        while (!b_ok && t < 200) begin
            @(negedge clk);
            b_hs = m_bvalid[n] && m_bready[n];
            @(posedge clk);
            #1;
            if (b_hs) b_ok = 1'b1;
            t++;
        end
        m_bready[n] = 1'b0;
        chk("b_timeout", {63'd0, b_ok}, 64'd1);
    endtask

    // Slave device: accept AW/W, answer with B after bdelay cycles
    bit              s_got_aw, s_got_w, s_rst, s_aw_hs, s_w_hs, s_b_hs;
    logic [ID_W-1:0] s_cap_id, s_id_smp;
    int              s_cnt;
    initial begin
        sl_bvalid = 1'b0;
        sl_bid    = '0;
        sl_bresp  = '0;
        s_got_aw  = 1'b0;
        s_got_w   = 1'b0;
        s_cnt     = 0;
        forever begin
            @(negedge clk);
            s_rst    = areset;
            s_aw_hs  = bus.s_awvalid_o && sl_awready;
            s_w_hs   = bus.s_wvalid_o && sl_wready;
            s_b_hs   = sl_bvalid && bus.s_bready_o;
            s_id_smp = bus.s_awid_o;
            @(posedge clk);
            #1;
            if (s_rst) begin
                sl_bvalid = 1'b0;
                s_got_aw  = 1'b0;
                s_got_w   = 1'b0;
                s_cnt     = 0;
            end else begin
                if (s_b_hs) sl_bvalid = 1'b0;
                if (s_aw_hs) begin
                    s_got_aw = 1'b1;
                    s_cap_id = s_id_smp;
                end
                if (s_w_hs) s_got_w = 1'b1;
                if (s_got_aw && s_got_w && !sl_bvalid) begin
                    if (s_cnt >= bdelay) begin
                        sl_bvalid = 1'b1;
                        sl_bid    = s_cap_id;
                        sl_bresp  = bresp_cfg;
                        s_got_aw  = 1'b0;
                        s_got_w   = 1'b0;
                        s_cnt     = 0;
                    end else begin
                        s_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pop expectations on grants and handshakes
    logic [1:0] prev_g = 2'b00;
    bit         seen_aw, seen_w;
    initial begin
        logic [1:0] g;
        forever begin
            @(negedge clk);
            g = grant_o;
            if (areset) begin
                prev_g  = 2'b00;
                seen_aw = 1'b0;
                seen_w  = 1'b0;
            end else begin
                if (g !== prev_g) begin
                    if (prev_g == 2'b00) begin
                        seen_aw = 1'b0;
                        seen_w  = 1'b0;
                        if (exp_grant.size() == 0)
                            chk("grant_unexpected", {62'd0, g}, 64'd0);
                        else
                            chk("grant", {62'd0, g},
                                {62'd0, exp_grant.pop_front()});
                    end else begin
                        chk("grant_hold", {62'd0, g}, 64'd0);
                    end
                end
                chk("busy", {63'd0, busy_o}, {63'd0, g != 2'b00});
                if (bus.s_awvalid_o && sl_awready) begin
                    seen_aw = 1'b1;
                    if (exp_aw.size() == 0)
                        chk("aw_unexpected", 64'd1, 64'd0);
                    else
                        chk("aw_fields", {28'd0, bus.s_awid_o, bus.s_awaddr_o},
                            {28'd0, exp_aw.pop_front()});
                end
                if (bus.s_wvalid_o && sl_wready) begin
                    seen_w = 1'b1;
                    if (exp_w.size() == 0)
                        chk("w_unexpected", 64'd1, 64'd0);
                    else
                        chk("w_fields", {28'd0, bus.s_wdata_o, bus.s_wstrb_o},
                            {28'd0, exp_w.pop_front()});
                end
                for (int n = 0; n < 2; n++) begin
                    if (m_bvalid[n] && m_bready[n]) begin
                        logic nb;
                        nb = n[0];
                        if (exp_b.size() == 0)
                            chk("b_unexpected", 64'd1, 64'd0);
                        else
                            chk("b_fields", {57'd0, nb, m_bid[n], m_bresp[n]},
                                {57'd0, exp_b.pop_front()});
                    end
                    if (!g[n])
                        chk("ungranted_master",
                            {55'd0, m_awready[n], m_wready[n], m_bvalid[n],
                             m_bid[n], m_bresp[n]}, 64'd0);
                end
                if (bus.s_bready_o)
                    chk("resp_before_aw_w", {63'd0, seen_aw && seen_w}, 64'd1);
                if (g == 2'b00)
                    chk("idle_slave", {61'd0, bus.s_awvalid_o,
                        bus.s_wvalid_o, bus.s_bready_o}, 64'd0);
            end
            prev_g = g;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit aw_hs;
        bit aw_ok;
        for (int n = 0; n < 2; n++) begin
            m_awid[n] = '0;   m_awaddr[n] = '0; m_awvalid[n] = 1'b0;
            m_wdata[n] = '0;  m_wstrb[n] = '0;  m_wvalid[n] = 1'b0;
            m_bready[n] = 1'b0;
        end
        sl_awready = 1'b1;
        sl_wready  = 1'b1;
        bdelay     = 0;
        bresp_cfg  = 2'b00;

        // Reset with a live request: nothing may leak out
        m_awvalid[0] = 1'b1;
        m_wvalid[0]  = 1'b1;
        m_bready[0]  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", {62'd0, grant_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_m0_hs", {61'd0, m_awready[0], m_wready[0], m_bvalid[0]}, 64'd0);
        chk("rst_slave", {61'd0, bus.s_awvalid_o, bus.s_wvalid_o,
                          bus.s_bready_o}, 64'd0);
        chk("rst_data", {bus.s_awaddr_o, bus.s_wdata_o}, 64'd0);
        m_awvalid[0] = 1'b0;
        m_wvalid[0]  = 1'b0;
        m_bready[0]  = 1'b0;
        areset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single request and one-cycle grant latency
        push(0, 4'h3, 32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
        fork
            m_write(0, 4'h3, 32'h4, 32'hDEADBEEF, 4'hF, 0, 1'b0);
            begin
                @(negedge clk);
                chk("lat_before", {62'd0, grant_o}, 64'd0);
                @(negedge clk);
                chk("lat_grant", {62'd0, grant_o}, 64'd1);
            end
        join
        @(posedge clk);
        #1;

        // Simultaneous requests, m0 keeps requesting
`ifdef AXI_WR_ARB_RR_EN
        push(0, 4'h1, 32'h100, 32'h11111111, 4'hF, 2'b00);
        push(1, 4'h9, 32'h200, 32'h99999999, 4'h1, 2'b00);
        push(0, 4'h2, 32'h104, 32'h22222222, 4'h3, 2'b00);
        push(0, 4'h4, 32'h108, 32'h44444444, 4'h8, 2'b00);
`else
        push(0, 4'h1, 32'h100, 32'h11111111, 4'hF, 2'b00);
        push(0, 4'h2, 32'h104, 32'h22222222, 4'h3, 2'b00);
        push(0, 4'h4, 32'h108, 32'h44444444, 4'h8, 2'b00);
        push(1, 4'h9, 32'h200, 32'h99999999, 4'h1, 2'b00);
`endif
        fork
            begin
                m_write(0, 4'h1, 32'h100, 32'h11111111, 4'hF, 0, 1'b0);
                m_write(0, 4'h2, 32'h104, 32'h22222222, 4'h3, 0, 1'b0);
                m_write(0, 4'h4, 32'h108, 32'h44444444, 4'h8, 0, 1'b0);
            end
            m_write(1, 4'h9, 32'h200, 32'h99999999, 4'h1, 0, 1'b0);
        join
        @(posedge clk);
        #1;

        // W leads AW by 3 cycles; slave then delays AW ready
        sl_awready = 1'b0;
        push(1, 4'h5, 32'h300, 32'h12345678, 4'h3, 2'b00);
        fork
            m_write(1, 4'h5, 32'h300, 32'h12345678, 4'h3, 3, 1'b1);
            begin
                repeat (7) @(posedge clk);
                #1;
                sl_awready = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Slave stalls B 5 cycles while m1 waits; SLVERR response
        bdelay    = 5;
        bresp_cfg = 2'b10;
        push(0, 4'h7, 32'h400, 32'hA5A5A5A5, 4'hC, 2'b10);
        push(1, 4'hA, 32'h500, 32'h5A5A5A5A, 4'h6, 2'b10);
        fork
            m_write(0, 4'h7, 32'h400, 32'hA5A5A5A5, 4'hC, 0, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1;
                m_write(1, 4'hA, 32'h500, 32'h5A5A5A5A, 4'h6, 0, 1'b0);
            end
        join
        bdelay    = 0;
        bresp_cfg = 2'b00;
        @(posedge clk);
        #1;

        // Reset mid-XFER after AW, before W
        sl_wready = 1'b0;
        exp_grant.push_back(2'b01);
        exp_aw.push_back({4'hB, 32'h700});
        m_awid[0]    = 4'hB;
        m_awaddr[0]  = 32'h700;
        m_wdata[0]   = 32'h77777777;
        m_wstrb[0]   = 4'hF;
        m_awvalid[0] = 1'b1;
        m_wvalid[0]  = 1'b1;
        aw_ok = 1'b0;
        for (int t = 0; t < 20 && !aw_ok; t++) begin
            @(negedge clk);
            aw_hs = m_awvalid[0] && m_awready[0];
            @(posedge clk);
            #1;
            if (aw_hs) begin
                m_awvalid[0] = 1'b0;
                aw_ok = 1'b1;
            end
        end
        chk("rst_mid_aw_done", {63'd0, aw_ok}, 64'd1);
        chk("rst_mid_busy_before", {63'd0, busy_o}, 64'd1);
        areset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_grant", {62'd0, grant_o}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_mid_hs", {59'd0, m_awready[0], m_wready[0], m_bvalid[0],
                           bus.s_awvalid_o, bus.s_wvalid_o}, 64'd0);
        chk("rst_mid_bready", {63'd0, bus.s_bready_o}, 64'd0);
        areset = 1'b0;
        m_wvalid[0] = 1'b0;
        sl_wready = 1'b1;
        @(posedge clk);
        #1;
        push(0, 4'hC, 32'h600, 32'hCAFEF00D, 4'hF, 2'b00);
        m_write(0, 4'hC, 32'h600, 32'hCAFEF00D, 4'hF, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("queues_empty", exp_grant.size() + exp_aw.size()
            + exp_w.size() + exp_b.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
